pipe_stage_skid: RTL and testbench

//  Generic, parametrised pipeline register stage with valid/ready handshake and a
//  one-entry skid buffer. Successor to the fixed-width write/flush-gated inter-stage

---
 rtl/pipe_stage_skid_if.sv | 14 +
 rtl/pipe_stage_skid.sv | 107 ++++++++++
 tb/tb_pipe_stage_skid.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying control bits and payload between pipeline stages.
// The master drives valid/ctrl/data and the slave answers with ready.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2
) ();
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a one-entry skid buffer, synchronous flush and a
// saturating stall counter. Every output is either a register or decoded from state.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_stallClr,
  pipe_stage_skid_if.slave     i_up,
  pipe_stage_skid_if.master    o_dn,
  output logic [1:0]           o_occupancy,
  output logic [CNT_W-1:0]     o_stallCount
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            r_state;
  logic [CTRL_W-1:0] r_mainCtrl;
  logic [DATA_W-1:0] r_mainData;
  logic [CTRL_W-1:0] r_skidCtrl;
  logic [DATA_W-1:0] r_skidData;
  logic [CNT_W-1:0]  r_stallCount;

  logic w_inFire;
  logic w_outFire;
  logic w_stall;

  // Ready depends only on state, so backpressure never forms a combinational path.
  assign w_inFire  = i_up.valid && (r_state != SKID);
  assign w_outFire = (r_state != EMPTY) && o_dn.ready;
  assign w_stall   = (r_state != EMPTY) && !o_dn.ready;

  assign i_up.ready   = (r_state != SKID);
  assign o_dn.valid   = (r_state != EMPTY);
  assign o_dn.ctrl    = r_mainCtrl;
  assign o_dn.data    = r_mainData;
  assign o_occupancy  = r_state;
  assign o_stallCount = r_stallCount;

  // Main register is the FIFO head; registers are zeroed whenever they hold no entry.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state    <= EMPTY;
      r_mainCtrl <= '0;
      r_mainData <= '0;
      r_skidCtrl <= '0;
      r_skidData <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            r_state    <= FULL;
            r_mainCtrl <= i_up.ctrl;
            r_mainData <= i_up.data;
          end
        end
        FULL: begin
          if (w_inFire && w_outFire) begin
            r_mainCtrl <= i_up.ctrl;
            r_mainData <= i_up.data;
          end else if (w_inFire) begin
            r_state    <= SKID;
            r_skidCtrl <= i_up.ctrl;
            r_skidData <= i_up.data;
          end else if (w_outFire) begin
            r_state    <= EMPTY;
            r_mainCtrl <= '0;
            r_mainData <= '0;
          end
        end
        SKID: begin
          if (w_outFire) begin
            r_state    <= FULL;
            r_mainCtrl <= r_skidCtrl;
            r_mainData <= r_skidData;
            r_skidCtrl <= '0;
            r_skidData <= '0;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_mainCtrl <= '0;
          r_mainData <= '0;
          r_skidCtrl <= '0;
          r_skidData <= '0;
        end
      endcase
    end
  end

  // Flush deliberately leaves the stall statistic untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_stallClr) begin
      r_stallCount <= '0;
    end else if (w_stall && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a queue-based model checked every cycle, plus directed
// scenarios with literal expectations and a long random valid/ready run.
module tb_pipe_stage_skid;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 2;
  localparam int CNT_W  = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             stallClr = 1'b0;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stallCount;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 1'b0;

  logic [CTRL_W+DATA_W-1:0] modelQ[$];
  int                       modelStall = 0;
  logic [DATA_W-1:0]        watchData = '1;
  bit                       sawWatch = 1'b0;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) upIf ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dnIf ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_stallClr   (stallClr),
    .i_up         (upIf.slave),
    .o_dn         (dnIf.master),
    .o_occupancy  (occupancy),
    .o_stallCount (stallCount)
  );

  always #5 clk = ~clk;

  task automatic compareField(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: a FIFO of at most two entries and a saturating stall counter.
  always @(posedge clk) begin : model
    bit inF;
    bit outF;
    if (rst) begin
      modelQ.delete();
      modelStall = 0;
    end else begin
      if (stallClr) modelStall = 0;
      else if (modelQ.size() > 0 && !dnIf.ready && modelStall < STALL_MAX) modelStall++;
      if (flush) begin
        modelQ.delete();
      end else begin
        inF  = upIf.valid && (modelQ.size() < 2);
        outF = (modelQ.size() > 0) && dnIf.ready;
        if (outF) void'(modelQ.pop_front());
        if (inF) modelQ.push_back({upIf.ctrl, upIf.data});
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [CTRL_W+DATA_W-1:0] head;
    if (checkEn) begin
      head = (modelQ.size() > 0) ? modelQ[0] : '0;
      compareField("cyc.outValid", 64'(dnIf.valid), 64'(modelQ.size() > 0));
      compareField("cyc.outCtrl", 64'(dnIf.ctrl), 64'(head[CTRL_W+DATA_W-1:DATA_W]));
      compareField("cyc.outData", 64'(dnIf.data), 64'(head[DATA_W-1:0]));
      compareField("cyc.occupancy", 64'(occupancy), 64'(modelQ.size()));
      compareField("cyc.inReady", 64'(upIf.ready), 64'(modelQ.size() < 2));
      compareField("cyc.stallCount", 64'(stallCount), 64'(modelStall));
      if (dnIf.valid === 1'b1 && dnIf.ready === 1'b1 && dnIf.data === watchData) sawWatch = 1'b1;
    end
  end

  task automatic applyStimulus(input logic r, input logic f, input logic c, input logic v,
                               input logic [CTRL_W-1:0] ctl, input logic [DATA_W-1:0] dat,
                               input logic rdy);
    rst        = r;
    flush      = f;
    stallClr   = c;
    upIf.valid = v;
    upIf.ctrl  = ctl;
    upIf.data  = dat;
    dnIf.ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [CTRL_W-1:0] expCtrl,
                             input logic [DATA_W-1:0] expData, input logic [1:0] expOcc,
                             input logic expInReady, input logic [CNT_W-1:0] expStall);
    compareField({name, ".outValid"}, 64'(dnIf.valid), 64'(expValid));
    compareField({name, ".outCtrl"}, 64'(dnIf.ctrl), 64'(expCtrl));
    compareField({name, ".outData"}, 64'(dnIf.data), 64'(expData));
    compareField({name, ".occupancy"}, 64'(occupancy), 64'(expOcc));
    compareField({name, ".inReady"}, 64'(upIf.ready), 64'(expInReady));
    compareField({name, ".stallCount"}, 64'(stallCount), 64'(expStall));
  endtask

  initial begin
    upIf.valid = 1'b0;
    upIf.ctrl  = '0;
    upIf.data  = '0;
    dnIf.ready = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 2'd0, 32'h0, 0);
    checkEn = 1'b1;
    checkOutput("reset", 0, 2'd0, 32'h0, 2'd0, 1, 4'd0);

    $display("[TB] streaming");
    applyStimulus(0, 0, 0, 1, 2'd1, 32'h11, 1);
    checkOutput("stream11", 1, 2'd1, 32'h11, 2'd1, 1, 4'd0);
    applyStimulus(0, 0, 0, 1, 2'd2, 32'h22, 1);
    checkOutput("stream22", 1, 2'd2, 32'h22, 2'd1, 1, 4'd0);
    applyStimulus(0, 0, 0, 1, 2'd3, 32'h33, 1);
    checkOutput("stream33", 1, 2'd3, 32'h33, 2'd1, 1, 4'd0);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    checkOutput("streamDrain", 0, 2'd0, 32'h0, 2'd0, 1, 4'd0);

    $display("[TB] backpressure");
    applyStimulus(0, 0, 0, 1, 2'd1, 32'hA1, 0);
    checkOutput("bpA1", 1, 2'd1, 32'hA1, 2'd1, 1, 4'd0);
    applyStimulus(0, 0, 0, 1, 2'd2, 32'hA2, 0);
    checkOutput("bpA2", 1, 2'd1, 32'hA1, 2'd2, 0, 4'd1);
    applyStimulus(0, 0, 0, 1, 2'd3, 32'hA3, 0);
    checkOutput("bpHeld", 1, 2'd1, 32'hA1, 2'd2, 0, 4'd2);
    applyStimulus(0, 0, 0, 1, 2'd3, 32'hA3, 1);
    checkOutput("bpOutA2", 1, 2'd2, 32'hA2, 2'd1, 1, 4'd2);
    applyStimulus(0, 0, 0, 1, 2'd3, 32'hA3, 1);
    checkOutput("bpOutA3", 1, 2'd3, 32'hA3, 2'd1, 1, 4'd2);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    checkOutput("bpDrain", 0, 2'd0, 32'h0, 2'd0, 1, 4'd2);

    $display("[TB] flush");
    applyStimulus(0, 0, 0, 1, 2'd1, 32'hB1, 0);
    checkOutput("flB1", 1, 2'd1, 32'hB1, 2'd1, 1, 4'd2);
    applyStimulus(0, 0, 0, 1, 2'd2, 32'hB2, 0);
    checkOutput("flB2", 1, 2'd1, 32'hB1, 2'd2, 0, 4'd3);
    watchData = 32'hB3;
    sawWatch  = 1'b0;
    applyStimulus(0, 1, 0, 1, 2'd3, 32'hB3, 0);
    checkOutput("flFlush", 0, 2'd0, 32'h0, 2'd0, 1, 4'd4);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    checkOutput("flAfter", 0, 2'd0, 32'h0, 2'd0, 1, 4'd4);
    compareField("flNoB3", 64'(sawWatch), 64'd0);

    $display("[TB] saturation");
    applyStimulus(0, 0, 1, 0, 2'd0, 32'h0, 0);
    checkOutput("satClr0", 0, 2'd0, 32'h0, 2'd0, 1, 4'd0);
    applyStimulus(0, 0, 0, 1, 2'd3, 32'hC1, 0);
    checkOutput("satC1", 1, 2'd3, 32'hC1, 2'd1, 1, 4'd0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 0);
    checkOutput("satMax", 1, 2'd3, 32'hC1, 2'd1, 1, 4'd15);
    applyStimulus(0, 0, 1, 0, 2'd0, 32'h0, 0);
    checkOutput("satClr", 1, 2'd3, 32'hC1, 2'd1, 1, 4'd0);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 0);
    checkOutput("satResume", 1, 2'd3, 32'hC1, 2'd1, 1, 4'd1);

    $display("[TB] reset priority");
    watchData = 32'hD1;
    sawWatch  = 1'b0;
    applyStimulus(1, 1, 0, 1, 2'd1, 32'hD1, 1);
    checkOutput("rstPrio", 0, 2'd0, 32'h0, 2'd0, 1, 4'd0);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    checkOutput("rstAfter", 0, 2'd0, 32'h0, 2'd0, 1, 4'd0);
    compareField("rstNoD1", 64'(sawWatch), 64'd0);

    $display("[TB] random traffic");
    watchData = '1;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 1999) == 0), ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                    CTRL_W'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 2) != 0));
    end
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 2'd0, 32'h0, 1);
    applyStimulus(0, 0, 1, 0, 2'd0, 32'h0, 1);
    checkOutput("randDrain", 0, 2'd0, 32'h0, 2'd0, 1, 4'd0);

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
